seq_pattern_player: RTL
=======================

# seq_pattern_player

Parametrised, programmable pattern sequencer: plays a run-time loadable table of DATA_W-bit values, one entry per step, with the step period set by an internal prescaler. The prescaler is a clock-enable, not a derived clock, so everything runs on the single system clock. Supports looping and one-shot modes, start/stop/restart control and a completion pulse. It sits between control logic and display or output drivers that need a timed value sequence.

## Interface
- DATA_W, 4: width of each pattern entry and of `result`.
- DEPTH, 8: number of pattern entries (power of two, ≥2). AW = $clog2(DEPTH).
- DIV_W, 8: width of the prescaler compare value.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- div_val  in  DIV_W  step period minus one (period = div_val+1 cycles); read continuously.
- wr_en  in  1  pattern table write strobe.
- wr_addr  in  AW  table write index.
- wr_data  in  DATA_W  table write data.
- last_idx  in  AW  final index played; sampled on accepted start.
- one_shot  in  1  1 = play once, 0 = loop; sampled on accepted start.
- start  in  1  begin or restart playback at index 0.
- stop  in  1  abort playback.
- result  out  DATA_W  current pattern value (registered).
- step  out  1  one-cycle pulse: `result` loaded with a new entry this cycle.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse: one-shot playback finished.

## Operation
- Table: DEPTH×DATA_W registers, all cleared to 0 by reset. A write takes effect on the next edge and is legal at any time, including during RUN.
- States: IDLE and RUN. Reset → IDLE with result=0, step=0, busy=0, done=0, idx=0, prescaler=0.
- IDLE:
  - result=0.
  - start=1 and stop=0 → RUN; latch last_idx and one_shot; idx←0; prescaler←0; result←table[0]; step←1.
- RUN:
  - The prescaler increments each cycle. Tick = (prescaler ≥ div_val). The ≥ compare means a lowered div_val mid-run never causes a wraparound stall.
  - On tick, prescaler←0, then:
    - If idx ≠ last_idx_q: idx←idx+1; result←table[idx+1]; step←1.
    - If idx = last_idx_q and loop mode: idx←0; result←table[0]; step←1.
    - If idx = last_idx_q and one-shot mode: → IDLE; result←0; done←1; step←0.
- start in RUN (stop=0) restarts: identical to start from IDLE, with new last_idx/one_shot latched. Restart has priority over a coincident tick.
- stop=1 (any state) → IDLE, result←0, no done pulse. stop wins over a simultaneous start.
- Table read/write same entry, same cycle: result takes the old contents (read before write).
- last_idx_q=0: a single entry is played. Loop mode reloads table[0] with step each period.
- div_val=0: a new entry every cycle.

## Timing
- Start accepted at edge N → busy=1, step=1, result=table[0] at N+1.
- Each entry is held exactly div_val+1 cycles, with div_val constant. step pulses at the first cycle of each entry.
- One-shot: the last entry is held a full period. On the following edge, busy=0, done=1 for one cycle, and result=0.
- stop at edge N → busy=0, result=0 at N+1.
- A div_val change applies from the next cycle's compare.
- A reset asserted mid-run returns all outputs to reset values at the next edge. The table is cleared.

## Test plan
- Reset, no start → result=0, busy=0, step=0, done=0 for 20 cycles.
- Load 0,0,8,5,7,0,0,5 into entries 0..7; last_idx=7, one_shot=0, div_val=1; start → result 0,0,8,5,7,0,0,5 repeated, each held 2 cycles, step every 2 cycles, busy stays 1, done never asserts.
- Same table, one_shot=1, div_val=2, last_idx=3 → 0,0,8,5 each held 3 cycles; then done=1 for one cycle, busy=0, result=0.
- Looping at div_val=3: stop mid-entry → result=0, busy=0 next cycle, no done. start+stop together from IDLE → stays IDLE.
- Looping at div_val=0: pulse start at index 5 → next cycle result=table[0]; write entry 2 ←9 during RUN → 9 appears on the next pass; div_val changed 200→0 mid-entry → advance on the next cycle.
- last_idx=0, loop, div_val=0 → result=table[0] constant, step high every cycle. Reset mid-run → all outputs 0, table reads 0 on restart.

Source files
------------

// File: rtl/seq_pattern_player.sv
// Programmable pattern sequencer: plays a loadable table of DATA_W-bit entries,
// one per step, paced by a clock-enable prescaler. Supports loop and one-shot modes.
module seq_pattern_player #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int DIV_W  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIV_W-1:0]  div_val,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     last_idx,
    input  logic              one_shot,
    input  logic              start,
    input  logic              stop,
    output logic [DATA_W-1:0] result,
    output logic              step,
    output logic              busy,
    output logic              done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d, idx_inc;
    logic [DIV_W-1:0]    presc_q, presc_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                step_q, step_d;
    logic                done_q, done_d;
    logic [AW-1:0]       last_q, last_d;
    logic                os_q, os_d;
    logic                tick;
    logic [DATA_W-1:0]   pat_mem [DEPTH];

    // Pattern table; reads below see the pre-write contents on a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pat_mem[i] <= '0;
            end
        end else if (wr_en) begin
            pat_mem[wr_addr] <= wr_data;
        end
    end

    assign idx_inc = idx_q + AW'(1);
    // >= rather than == so a lowered div_val never forces a full wraparound.
    assign tick    = (presc_q >= div_val);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        presc_d  = presc_q;
        result_d = result_q;
        step_d   = 1'b0;
        done_d   = 1'b0;
        last_d   = last_q;
        os_d     = os_q;

        unique case (state_q)
            IDLE: begin
                result_d = '0;
                if (start && !stop) begin
                    state_d  = RUN;
                    last_d   = last_idx;
                    os_d     = one_shot;
                    idx_d    = '0;
                    presc_d  = '0;
                    result_d = pat_mem[0];
                    step_d   = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    presc_d  = '0;
                    result_d = '0;
                end else if (start) begin
                    last_d   = last_idx;
                    os_d     = one_shot;
                    idx_d    = '0;
                    presc_d  = '0;
                    result_d = pat_mem[0];
                    step_d   = 1'b1;
                end else if (tick) begin
                    presc_d = '0;
                    if (idx_q != last_q) begin
                        idx_d    = idx_inc;
                        result_d = pat_mem[idx_inc];
                        step_d   = 1'b1;
                    end else if (!os_q) begin
                        idx_d    = '0;
                        result_d = pat_mem[0];
                        step_d   = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        idx_d    = '0;
                        result_d = '0;
                        done_d   = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            presc_q  <= '0;
            result_q <= '0;
            step_q   <= 1'b0;
            done_q   <= 1'b0;
            last_q   <= '0;
            os_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            presc_q  <= presc_d;
            result_q <= result_d;
            step_q   <= step_d;
            done_q   <= done_d;
            last_q   <= last_d;
            os_q     <= os_d;
        end
    end

    assign result = result_q;
    assign step   = step_q;
    assign busy   = (state_q == RUN);
    assign done   = done_q;

endmodule
